// File: rtl/rvfi_retire_buffer.sv
// RVFI retirement-trace buffer: compacts sparse retire lanes, stamps order numbers,
// and queues records in a circular FIFO drained under consumer backpressure.
module rvfi_retire_buffer #(
  parameter int NR_IN   = 2,
  parameter int NR_OUT  = 1,
  parameter int REC_W   = 512,
  parameter int DEPTH   = 16,
  parameter int ORDER_W = 64,
  parameter int DROP_W  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NR_IN-1:0]            in_valid_i,
  input  logic [NR_IN*REC_W-1:0]      in_record_i,
  output logic [NR_OUT-1:0]           out_valid_o,
  output logic [NR_OUT*REC_W-1:0]     out_record_o,
  output logic [NR_OUT*ORDER_W-1:0]   out_order_o,
  input  logic                        out_ready_i,
  input  logic                        clear_i,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overflow_o,
  output logic [DROP_W-1:0]           drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so DEPTH - count + deq_n never wraps.
  localparam int N_W   = CNT_W + 1;
  localparam int SAT_W = DROP_W + N_W;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < NR_IN + NR_OUT)) begin : g_bad_cfg
    $error("rvfi_retire_buffer: DEPTH must be a power of two and >= NR_IN+NR_OUT");
  end

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [N_W-1:0]    b);
    logic [SAT_W-1:0] sum;
    sum = SAT_W'(a) + SAT_W'(b);
    if (sum > SAT_W'({DROP_W{1'b1}})) sat_add = {DROP_W{1'b1}};
    else                              sat_add = sum[DROP_W-1:0];
  endfunction

  logic [REC_W-1:0]   rec_mem [DEPTH];
  logic [ORDER_W-1:0] ord_mem [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [ORDER_W-1:0] order_q;
  logic               overflow_q;
  logic [DROP_W-1:0]  drop_cnt_q;

  logic [N_W-1:0]     lane_k [NR_IN];
  logic [N_W-1:0]     valid_n, deq_n, free_n, acc_n, drop_n;

  // Compaction slot per lane and free-space accounting
  always_comb begin
    valid_n = '0;
    for (int i = 0; i < NR_IN; i++) begin
      lane_k[i] = valid_n;
      valid_n   = valid_n + N_W'(in_valid_i[i]);
    end
    deq_n = '0;
    if (out_ready_i)
      deq_n = (N_W'(count_q) > N_W'(NR_OUT)) ? N_W'(NR_OUT) : N_W'(count_q);
    free_n = N_W'(DEPTH) - N_W'(count_q) + deq_n;
    acc_n  = (valid_n < free_n) ? valid_n : free_n;
    drop_n = valid_n - acc_n;
  end

  // Storage write: accepted lanes land contiguously from the write pointer
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_IN; i++) begin
      if (in_valid_i[i] && (lane_k[i] < acc_n)) begin
        rec_mem[wr_ptr_q + PTR_W'(lane_k[i])] <= in_record_i[i*REC_W +: REC_W];
        ord_mem[wr_ptr_q + PTR_W'(lane_k[i])] <= order_q + ORDER_W'(lane_k[i]);
      end
    end
  end

  // Control state: pointers, occupancy, order counter, loss reporting
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      order_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(deq_n);
      wr_ptr_q <= wr_ptr_q + PTR_W'(acc_n);
      count_q  <= CNT_W'(N_W'(count_q) + acc_n - deq_n);
      // Dropped records still consume order numbers so the consumer sees the gap.
      order_q  <= order_q + ORDER_W'(valid_n);
      if (drop_n != '0) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= clear_i ? sat_add('0, drop_n) : sat_add(drop_cnt_q, drop_n);
      end else if (clear_i) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end
    end
  end

  for (genvar j = 0; j < NR_OUT; j++) begin : g_out
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx                              = rd_ptr_q + PTR_W'(j);
    assign out_valid_o[j]                      = count_q > CNT_W'(j);
    assign out_record_o[j*REC_W +: REC_W]      = rec_mem[rd_idx];
    assign out_order_o[j*ORDER_W +: ORDER_W]   = ord_mem[rd_idx];
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Scoreboard bench for rvfi_retire_buffer: directed retire patterns, a monitor
// compares every consumed record and order stamp against the expected queue.
module tb_rvfi_retire_buffer;

  localparam int NR_IN   = 2;
  localparam int NR_OUT  = 1;
  localparam int REC_W   = 32;
  localparam int DEPTH   = 16;
  localparam int ORDER_W = 4;
  localparam int DROP_W  = 16;

  logic                      clk_i;
  logic                      rst_ni;
  logic [NR_IN-1:0]          in_valid_i;
  logic [NR_IN*REC_W-1:0]    in_record_i;
  logic [NR_OUT-1:0]         out_valid_o;
  logic [NR_OUT*REC_W-1:0]   out_record_o;
  logic [NR_OUT*ORDER_W-1:0] out_order_o;
  logic                      out_ready_i;
  logic                      clear_i;
  logic [$clog2(DEPTH):0]    count_o;
  logic                      overflow_o;
  logic [DROP_W-1:0]         drop_cnt_o;

  rvfi_retire_buffer #(
    .NR_IN(NR_IN), .NR_OUT(NR_OUT), .REC_W(REC_W),
    .DEPTH(DEPTH), .ORDER_W(ORDER_W), .DROP_W(DROP_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_record_i(in_record_i),
    .out_valid_o(out_valid_o), .out_record_o(out_record_o), .out_order_o(out_order_o),
    .out_ready_i(out_ready_i), .clear_i(clear_i),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [REC_W-1:0]   rec;
    logic [ORDER_W-1:0] ord;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_tests = 0;
  int                 n_fail  = 0;
  int                 m_count = 0;
  logic [ORDER_W-1:0] m_order = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a record is consumed at the next rising edge when valid and ready.
  always @(negedge clk_i) begin
    if (rst_ni && out_ready_i && out_valid_o[0]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_record_o), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_record", 64'(out_record_o), 64'(e.rec));
        check("out_order",  64'(out_order_o),  64'(e.ord));
      end
    end
  end

  // Drive one cycle; the expected records the buffer must accept are queued.
  task automatic cycle(input logic [1:0] v, input logic [REC_W-1:0] a,
                       input logic [REC_W-1:0] b, input logic rdy, input logic clr);
    int deq, free, k;
    logic [REC_W-1:0] recs [2];
    recs[0] = a;
    recs[1] = b;
    in_valid_i  = v;
    in_record_i = {b, a};
    out_ready_i = rdy;
    clear_i     = clr;
    deq  = (rdy && m_count > 0) ? 1 : 0;
    free = DEPTH - m_count + deq;
    k = 0;
    for (int i = 0; i < NR_IN; i++) begin
      if (v[i]) begin
        if (k < free) exp_q.push_back('{rec: recs[i], ord: m_order + ORDER_W'(k)});
        k++;
      end
    end
    m_count = m_count + ((k < free) ? k : free) - deq;
    m_order = m_order + ORDER_W'(k);
    @(posedge clk_i);
    #1;
    in_valid_i = '0;
    clear_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid_i = '0;
    clear_i    = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    exp_q.delete();
    m_count = 0;
    m_order = '0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (count_o != 0 && n < max_cycles) begin
      cycle(2'b00, '0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_count", 64'(count_o), 64'd0);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = '0; in_record_i = '0; out_ready_i = 1'b0; clear_i = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset();
    check("rst_count",    64'(count_o),     64'd0);
    check("rst_valid",    64'(out_valid_o), 64'd0);
    check("rst_overflow", 64'(overflow_o),  64'd0);
    check("rst_drop_cnt", 64'(drop_cnt_o),  64'd0);

    // Basic ordering: A order 0, then B order 1
    cycle(2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 1'b0);
    check("basic_count_2", 64'(count_o), 64'd2);
    cycle(2'b00, '0, '0, 1'b1, 1'b0);
    check("basic_count_1", 64'(count_o), 64'd1);
    cycle(2'b00, '0, '0, 1'b1, 1'b0);
    check("basic_count_0", 64'(count_o), 64'd0);

    // Sparse: only lane 1 valid, stored at head with order 2
    cycle(2'b10, 32'hFFFF_FFFF, 32'hCCCC_0003, 1'b1, 1'b0);
    check("sparse_count", 64'(count_o),      64'd1);
    check("sparse_rec",   64'(out_record_o), 64'hCCCC_0003);
    check("sparse_order", 64'(out_order_o),  64'd2);
    drain(8);

    // Overflow: 9 double pushes into a 16-entry FIFO with no consumer
    do_reset();
    for (int i = 0; i < 9; i++)
      cycle(2'b11, 32'h1000_0000 + 32'(2*i), 32'h1000_0001 + 32'(2*i), 1'b0, 1'b0);
    check("ovf_count",    64'(count_o),    64'd16);
    check("ovf_flag",     64'(overflow_o), 64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt_o), 64'd2);
    // Full with simultaneous pop: one accepted (order 18 mod 16), one dropped
    cycle(2'b11, 32'h2000_0000, 32'h2000_0001, 1'b1, 1'b0);
    check("fullpop_count",    64'(count_o),    64'd16);
    check("fullpop_drop_cnt", 64'(drop_cnt_o), 64'd3);
    // Clear in the same cycle as a drop keeps only this cycle's drop
    cycle(2'b11, 32'h3000_0000, 32'h3000_0001, 1'b1, 1'b1);
    check("clrdrop_count",    64'(count_o),    64'd16);
    check("clrdrop_flag",     64'(overflow_o), 64'd1);
    check("clrdrop_drop_cnt", 64'(drop_cnt_o), 64'd1);
    cycle(2'b00, '0, '0, 1'b0, 1'b1);
    check("clear_flag",     64'(overflow_o), 64'd0);
    check("clear_drop_cnt", 64'(drop_cnt_o), 64'd0);
    drain(40);

    // Order wrap with a 4-bit stamp: 0..15 then 0..3
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(2'b01, 32'h5000_0000 + 32'(i), '0, 1'b1, 1'b0);
    check("wrap_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("wrap_flag",     64'(overflow_o), 64'd0);
    drain(8);

    // Reset mid-operation with count 5 and overflow set
    do_reset();
    for (int i = 0; i < 9; i++)
      cycle(2'b11, 32'h6000_0000 + 32'(2*i), 32'h6000_0001 + 32'(2*i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++)
      cycle(2'b00, '0, '0, 1'b1, 1'b0);
    check("mid_count_5", 64'(count_o),    64'd5);
    check("mid_flag",    64'(overflow_o), 64'd1);
    out_ready_i = 1'b0;
    do_reset();
    check("midrst_count",    64'(count_o),     64'd0);
    check("midrst_valid",    64'(out_valid_o), 64'd0);
    check("midrst_flag",     64'(overflow_o),  64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt_o),  64'd0);
    cycle(2'b01, 32'h7000_0007, '0, 1'b0, 1'b0);
    check("post_rst_count", 64'(count_o),      64'd1);
    check("post_rst_rec",   64'(out_record_o), 64'h7000_0007);
    check("post_rst_order", 64'(out_order_o),  64'd0);
    drain(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
